// File: rtl/vga_timing_gen_if.sv
// Bundle between vga_timing_gen and its pixel source / DAC. The generator is the master,
// and the pixel source together with the display side is the slave.
interface vga_timing_gen_if #(
  parameter int RW = 3,
  parameter int GW = 3,
  parameter int BW = 2
);
  logic [1:0]    MODE;
  logic [RW-1:0] PIX_R;
  logic [GW-1:0] PIX_G;
  logic [BW-1:0] PIX_B;
  logic          PIX_REQ;
  logic [9:0]    PIX_X;
  logic [9:0]    PIX_Y;
  logic [RW-1:0] VGA_R;
  logic [GW-1:0] VGA_G;
  logic [BW-1:0] VGA_B;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_DE;
  logic          FRAME_START;

  modport master (
    input  MODE, PIX_R, PIX_G, PIX_B,
    output PIX_REQ, PIX_X, PIX_Y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START
  );
  modport slave (
    output MODE, PIX_R, PIX_G, PIX_B,
    input  PIX_REQ, PIX_X, PIX_Y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, pixel request to an
// external source, and an SRC_LAT-deep output stage that lines colour up with DE/HS/VS.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int SRC_LAT  = 1,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2
) (
  input  logic             CLK_50M,
  input  logic             RST,
  vga_timing_gen_if.master bus
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW      = $clog2(H_TOTAL);
  localparam int   VW      = $clog2(V_TOTAL);
  localparam int   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic HS_ON   = (HS_POL != 0);
  localparam logic VS_ON   = (VS_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q;
  logic          fs_q;
  logic          pe, frame_origin;

  // Stage 0 drives PIX_REQ/PIX_X/PIX_Y; stage SRC_LAT drives the VGA outputs.
  logic [SRC_LAT:0]       vld_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [SRC_LAT:0][9:0]  x_pipe_q, y_pipe_q;

  logic [31:0] hx, vx;
  logic        act_raw, hs_raw, vs_raw;
  logic [9:0]  x_raw, y_raw;

  assign pe           = (div_q == DW'(CLK_DIV - 1));
  assign frame_origin = (h_q == '0) && (v_q == '0);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (pe) begin
      div_d = '0;
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Compare in 32 bits so a sync window ending exactly at the total never overflows.
  assign hx      = 32'(h_q);
  assign vx      = 32'(v_q);
  assign act_raw = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
  assign hs_raw  = (hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw  = (vx >= 32'(V_ACTIVE + V_FP)) && (vx < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign x_raw   = act_raw ? 10'(h_q) : 10'd0;
  assign y_raw   = act_raw ? 10'(v_q) : 10'd0;

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      mode_q     <= '0;
      fs_q       <= 1'b0;
      vld_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      x_pipe_q   <= '0;
      y_pipe_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= pe && frame_origin;
      if (pe) begin
        if (frame_origin) mode_q <= bus.MODE;
        vld_pipe_q <= {vld_pipe_q[SRC_LAT-1:0], act_raw};
        hs_pipe_q  <= {hs_pipe_q[SRC_LAT-1:0], hs_raw};
        vs_pipe_q  <= {vs_pipe_q[SRC_LAT-1:0], vs_raw};
        x_pipe_q   <= {x_pipe_q[SRC_LAT-1:0], x_raw};
        y_pipe_q   <= {y_pipe_q[SRC_LAT-1:0], y_raw};
      end
    end
  end

  logic [9:0]    xo, yo, bar_i;
  logic [10:0]   xy_sum;
  logic [2:0]    bar_c, bar_col;
  logic [RW-1:0] r_c;
  logic [GW-1:0] g_c;
  logic [BW-1:0] b_c;

  assign xo      = x_pipe_q[SRC_LAT];
  assign yo      = y_pipe_q[SRC_LAT];
  assign xy_sum  = {1'b0, xo} + {1'b0, yo};
  assign bar_i   = xo / 10'(BAR_W);
  assign bar_c   = (bar_i > 10'd7) ? 3'd7 : bar_i[2:0];
  assign bar_col = 3'd7 - bar_c;

  // External data is taken straight from the source, whose registered output already
  // updates on the same pe-tick as the output stage.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (vld_pipe_q[SRC_LAT]) begin
      case (mode_q)
        2'd0: begin
          r_c = bus.PIX_R;
          g_c = bus.PIX_G;
          b_c = bus.PIX_B;
        end
        2'd1: begin
          r_c = {RW{bar_col[2]}};
          g_c = {GW{bar_col[1]}};
          b_c = {BW{bar_col[0]}};
        end
        2'd2: begin
          r_c = RW'(xo >> 4);
          g_c = GW'(yo >> 4);
          b_c = BW'(xy_sum >> 4);
        end
        default: ;
      endcase
    end
  end

  assign bus.PIX_REQ     = vld_pipe_q[0];
  assign bus.PIX_X       = x_pipe_q[0];
  assign bus.PIX_Y       = y_pipe_q[0];
  assign bus.VGA_DE      = vld_pipe_q[SRC_LAT];
  assign bus.VGA_HS      = hs_pipe_q[SRC_LAT] ? HS_ON : ~HS_ON;
  assign bus.VGA_VS      = vs_pipe_q[SRC_LAT] ? VS_ON : ~VS_ON;
  assign bus.VGA_R       = r_c;
  assign bus.VGA_G       = g_c;
  assign bus.VGA_B       = b_c;
  assign bus.FRAME_START = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a short-frame 640-wide instance (CLK_DIV=1) and a tiny instance (CLK_DIV=3, HS_POL=1).
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   vec = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ba ();
  vga_timing_gen_if bb ();

  vga_timing_gen #(
    .CLK_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SRC_LAT(1)
  ) dut_a (.CLK_50M(clk), .RST(rst_a), .bus(ba));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1)
  ) dut_b (.CLK_50M(clk), .RST(rst_b), .bus(bb));

  // Pixel source for instance A: one-cycle registered echo of PIX_X[2:0] on red.
  always @(posedge clk) ba.PIX_R <= ba.PIX_X[2:0];
  assign ba.PIX_G = '0;
  assign ba.PIX_B = '0;
  assign bb.PIX_R = '0;
  assign bb.PIX_G = '0;
  assign bb.PIX_B = '0;

  task automatic wait_fs_a(input int bound);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      hit = (ba.FRAME_START === 1'b1);
    end
    vec++;
    if (!hit) begin errs++; $display("FAIL wait_fs: FRAME_START not seen within %0d cycles", bound); end
  endtask

  task automatic wait_de_a(input int bound);
    bit hit = 1'b0;
    logic p = ba.VGA_DE;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      hit = (ba.VGA_DE === 1'b1) && (p === 1'b0);
      p = ba.VGA_DE;
    end
    vec++;
    if (!hit) begin errs++; $display("FAIL wait_de: DE rise not seen within %0d cycles", bound); end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    ba.MODE = 2'd3; bb.MODE = 2'd3;
    repeat (3) @(negedge clk);
    vec++; if (ba.PIX_REQ !== 1'b0) begin errs++; $display("FAIL rst_req: got %0d want 0", ba.PIX_REQ); end
    vec++; if (ba.PIX_X !== 10'd0 || ba.PIX_Y !== 10'd0) begin errs++; $display("FAIL rst_xy: got %0d,%0d want 0,0", ba.PIX_X, ba.PIX_Y); end
    vec++; if (ba.VGA_DE !== 1'b0) begin errs++; $display("FAIL rst_de: got %0d want 0", ba.VGA_DE); end
    vec++; if (ba.VGA_HS !== 1'b1 || ba.VGA_VS !== 1'b1) begin errs++; $display("FAIL rst_sync: got hs=%0d vs=%0d want 1,1", ba.VGA_HS, ba.VGA_VS); end
    vec++; if (ba.FRAME_START !== 1'b0) begin errs++; $display("FAIL rst_fs: got %0d want 0", ba.FRAME_START); end
    vec++; if (ba.VGA_R !== 3'd0 || ba.VGA_G !== 3'd0 || ba.VGA_B !== 2'd0) begin errs++; $display("FAIL rst_rgb: got %0d,%0d,%0d want 0,0,0", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
    vec++; if (bb.VGA_HS !== 1'b0 || bb.VGA_VS !== 1'b1) begin errs++; $display("FAIL rst_b_sync: got hs=%0d vs=%0d want 0,1", bb.VGA_HS, bb.VGA_VS); end
  endtask

  // Mode 3 over two 800x8 frames: sync periods/widths, DE area, frame strobe spacing.
  task automatic test_timing;
    int fs_n = 0, fs_t2 = -1, de_n = 0, req_n = 0, col_n = 0, hs_lo = 0, vs_lo = 0;
    int hs_f0 = -1, hs_f1 = -1, vs_f0 = -1, vs_f1 = -1;
    logic hp, vp;
    rst_a = 1'b0;
    @(negedge clk);
    vec++; if (ba.FRAME_START !== 1'b1) begin errs++; $display("FAIL tim_fs_first: got %0d want 1", ba.FRAME_START); end
    hp = ba.VGA_HS; vp = ba.VGA_VS;
    for (int t = 0; t < 12800; t++) begin
      if (ba.FRAME_START === 1'b1) begin fs_n++; if (t > 0) fs_t2 = t; end
      if (t < 6400) begin
        de_n  += int'(ba.VGA_DE === 1'b1);
        req_n += int'(ba.PIX_REQ === 1'b1);
        hs_lo += int'(ba.VGA_HS === 1'b0);
        vs_lo += int'(ba.VGA_VS === 1'b0);
      end
      if (ba.VGA_R != 0 || ba.VGA_G != 0 || ba.VGA_B != 0) col_n++;
      if (hp === 1'b1 && ba.VGA_HS === 1'b0) begin if (hs_f0 < 0) hs_f0 = t; else if (hs_f1 < 0) hs_f1 = t; end
      if (vp === 1'b1 && ba.VGA_VS === 1'b0) begin if (vs_f0 < 0) vs_f0 = t; else if (vs_f1 < 0) vs_f1 = t; end
      hp = ba.VGA_HS; vp = ba.VGA_VS;
      @(negedge clk);
    end
    vec++; if (fs_n != 2) begin errs++; $display("FAIL tim_fs_count: got %0d want 2", fs_n); end
    vec++; if (fs_t2 != 6400) begin errs++; $display("FAIL tim_fs_period: got %0d want 6400", fs_t2); end
    vec++; if (de_n != 2560) begin errs++; $display("FAIL tim_de_count: got %0d want 2560", de_n); end
    vec++; if (req_n != 2560) begin errs++; $display("FAIL tim_req_count: got %0d want 2560", req_n); end
    vec++; if (hs_f0 != 657) begin errs++; $display("FAIL tim_hs_first: got %0d want 657", hs_f0); end
    vec++; if (hs_f1 - hs_f0 != 800) begin errs++; $display("FAIL tim_hs_period: got %0d want 800", hs_f1 - hs_f0); end
    vec++; if (hs_lo != 768) begin errs++; $display("FAIL tim_hs_low: got %0d want 768", hs_lo); end
    vec++; if (vs_lo != 1600) begin errs++; $display("FAIL tim_vs_low: got %0d want 1600", vs_lo); end
    vec++; if (vs_f1 - vs_f0 != 6400) begin errs++; $display("FAIL tim_vs_period: got %0d want 6400", vs_f1 - vs_f0); end
    vec++; if (col_n != 0) begin errs++; $display("FAIL tim_black: got %0d coloured samples want 0", col_n); end
  endtask

  task automatic test_external;
    int n = 9, col_n = 0;
    ba.MODE = 2'd0;
    wait_fs_a(7000);
    wait_de_a(1000);
    for (int k = 0; k < 9; k++) begin
      vec++; if (ba.VGA_R !== 3'(k % 8)) begin errs++; $display("FAIL ext_r%0d: got %0d want %0d", k, ba.VGA_R, k % 8); end
      @(negedge clk);
    end
    for (int i = 0; i < 1000 && ba.VGA_DE === 1'b1; i++) begin n++; @(negedge clk); end
    vec++; if (n != 640) begin errs++; $display("FAIL ext_line_len: got %0d want 640", n); end
    for (int i = 0; i < 150; i++) begin
      if (ba.VGA_R != 0 || ba.VGA_G != 0 || ba.VGA_B != 0) col_n++;
      @(negedge clk);
    end
    vec++; if (col_n != 0) begin errs++; $display("FAIL ext_blank: got %0d coloured samples want 0", col_n); end
  endtask

  task automatic test_bars_then_gradient;
    ba.MODE = 2'd1;
    wait_fs_a(7000);
    wait_de_a(1000);
    for (int k = 0; k <= 560; k++) begin
      if (k == 0 || k == 79) begin
        vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== {3'd7, 3'd7, 2'd3}) begin errs++; $display("FAIL bar_white_%0d: got %0d,%0d,%0d want 7,7,3", k, ba.VGA_R, ba.VGA_G, ba.VGA_B); end
      end
      if (k == 80) begin
        vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== {3'd7, 3'd7, 2'd0}) begin errs++; $display("FAIL bar_yellow: got %0d,%0d,%0d want 7,7,0", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
      end
      if (k == 560) begin
        vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== 8'd0) begin errs++; $display("FAIL bar_black: got %0d,%0d,%0d want 0,0,0", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
      end
      @(negedge clk);
    end
    wait_de_a(1000);
    wait_de_a(1000);
    ba.MODE = 2'd2;
    @(negedge clk);
    vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== {3'd7, 3'd7, 2'd3}) begin errs++; $display("FAIL bar_hold_midframe: got %0d,%0d,%0d want 7,7,3", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
    wait_fs_a(7000);
    wait_de_a(1000);
    for (int k = 0; k <= 320; k++) begin
      if (k == 100) begin
        vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== {3'd6, 3'd0, 2'd2}) begin errs++; $display("FAIL grad_100: got %0d,%0d,%0d want 6,0,2", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
      end
      if (k == 320) begin
        vec++; if ({ba.VGA_R, ba.VGA_G, ba.VGA_B} !== {3'd4, 3'd0, 2'd0}) begin errs++; $display("FAIL grad_320: got %0d,%0d,%0d want 4,0,0", ba.VGA_R, ba.VGA_G, ba.VGA_B); end
      end
      @(negedge clk);
    end
  endtask

  // Reset pulse while h=300, v=2 (active region), then restart from the frame origin.
  task automatic test_reset_midline;
    int hs_t = -1;
    ba.MODE = 2'd3;
    wait_fs_a(7000);
    repeat (1899) @(negedge clk);
    vec++; if (ba.PIX_X !== 10'd299) begin errs++; $display("FAIL mid_pre_x: got %0d want 299", ba.PIX_X); end
    rst_a = 1'b1;
    @(negedge clk);
    vec++; if (ba.PIX_REQ !== 1'b0 || ba.PIX_X !== 10'd0 || ba.PIX_Y !== 10'd0) begin errs++; $display("FAIL mid_rst_req: got req=%0d x=%0d y=%0d want 0,0,0", ba.PIX_REQ, ba.PIX_X, ba.PIX_Y); end
    vec++; if (ba.VGA_DE !== 1'b0 || ba.VGA_HS !== 1'b1 || ba.VGA_VS !== 1'b1) begin errs++; $display("FAIL mid_rst_out: got de=%0d hs=%0d vs=%0d want 0,1,1", ba.VGA_DE, ba.VGA_HS, ba.VGA_VS); end
    rst_a = 1'b0;
    @(negedge clk);
    vec++; if (ba.FRAME_START !== 1'b1) begin errs++; $display("FAIL mid_fs: got %0d want 1", ba.FRAME_START); end
    for (int t = 1; t < 1000 && hs_t < 0; t++) begin
      @(negedge clk);
      if (t == 1) begin
        vec++; if (ba.FRAME_START !== 1'b0) begin errs++; $display("FAIL mid_fs_width: got %0d want 0", ba.FRAME_START); end
      end
      if (ba.VGA_HS === 1'b0) hs_t = t;
    end
    vec++; if (hs_t != 657) begin errs++; $display("FAIL mid_hs_first: got %0d want 657", hs_t); end
  endtask

  // Tiny raster: 12x5, pe every 3 clocks, HS active-high for 2 pe-ticks.
  task automatic test_small;
    int hs_hi = 0, de_n = 0, req_run = 0, r0 = -1, r1 = -1, fs2 = -1;
    bit req_done = 1'b0;
    logic hp;
    rst_b = 1'b0;
    @(negedge clk);
    vec++; if (bb.FRAME_START !== 1'b0) begin errs++; $display("FAIL small_fs_n1: got %0d want 0", bb.FRAME_START); end
    @(negedge clk);
    vec++; if (bb.FRAME_START !== 1'b0) begin errs++; $display("FAIL small_fs_n2: got %0d want 0", bb.FRAME_START); end
    @(negedge clk);
    vec++; if (bb.FRAME_START !== 1'b1) begin errs++; $display("FAIL small_fs_n3: got %0d want 1", bb.FRAME_START); end
    hp = bb.VGA_HS;
    for (int t = 0; t < 360; t++) begin
      if (t == 1) begin
        vec++; if (bb.FRAME_START !== 1'b0) begin errs++; $display("FAIL small_fs_width: got %0d want 0", bb.FRAME_START); end
      end
      if (t > 0 && bb.FRAME_START === 1'b1 && fs2 < 0) fs2 = t;
      if (t < 180) begin
        hs_hi += int'(bb.VGA_HS === 1'b1);
        de_n  += int'(bb.VGA_DE === 1'b1);
      end
      if (!req_done) begin if (bb.PIX_REQ === 1'b1) req_run++; else req_done = 1'b1; end
      if (hp === 1'b0 && bb.VGA_HS === 1'b1) begin if (r0 < 0) r0 = t; else if (r1 < 0) r1 = t; end
      hp = bb.VGA_HS;
      @(negedge clk);
    end
    vec++; if (r0 != 30) begin errs++; $display("FAIL small_hs_first: got %0d want 30", r0); end
    vec++; if (r1 - r0 != 36) begin errs++; $display("FAIL small_hs_period: got %0d want 36", r1 - r0); end
    vec++; if (hs_hi != 30) begin errs++; $display("FAIL small_hs_high: got %0d want 30", hs_hi); end
    vec++; if (fs2 != 180) begin errs++; $display("FAIL small_fs_period: got %0d want 180", fs2); end
    vec++; if (de_n != 48) begin errs++; $display("FAIL small_de_count: got %0d want 48", de_n); end
    vec++; if (req_run != 24) begin errs++; $display("FAIL small_req_run: got %0d want 24", req_run); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_external();
    test_bars_then_gradient();
    test_reset_midline();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end
endmodule
